// File: rtl/config_loader_pkg.sv
// config_loader_pkg
// Shared definitions for the configuration-chain loader: the pass FSM state
// encoding and small helpers for sizing counters and indices.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  // Width of a counter that has to reach n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of a bit index into a w-bit word; never less than one bit.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Number of stream words needed to cover a chain of n bits.
  function automatic int words_per_pass(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// word_serializer
// Turns a valid/ready word stream into one chain bit per cycle, LSB first.
// A shift buffer holds the word being serialised and a skid register holds
// the next one, so a continuously valid stream produces no bubbles.
// Ports:
//   prog_clk, prog_rst_n : clock, asynchronous active-low reset
//   run                  : pass active; low empties both word registers
//   remaining            : chain bits not yet issued onto prog_in
//   s_data/s_valid/s_ready : input word stream
//   prog_in, prog_en     : registered serial data and shift enable
module word_serializer
  import config_loader_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 13
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              run,
  input  logic [CNT_W-1:0]  remaining,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_in,
  output logic              prog_en
);

  localparam int IDX_W = idx_width(WORD_W);

  logic [WORD_W-1:0] buf_q, buf_d, skid_q, skid_d, cur_word;
  logic [IDX_W-1:0]  idx_q, idx_d, cur_idx;
  logic              buf_v_q, buf_v_d, skid_v_q, skid_v_d, cur_v;
  logic              prog_in_q, prog_in_d, prog_en_q, prog_en_d;
  logic              s_hs, take_direct;
  logic [31:0]       held_bits;

  // Only ask for another word while the bits already held fall short of
  // what the chain still needs; this stops the pass at ceil(len/width) words.
  always_comb begin
    held_bits = (buf_v_q ? (32'(WORD_W) - 32'(idx_q)) : 32'd0) +
                (skid_v_q ? 32'(WORD_W) : 32'd0);
    s_ready   = run && !skid_v_q && (32'(remaining) > held_bits);
    s_hs      = s_valid && s_ready;
  end

  // Pick the word to serialise this cycle (buffer, then skid, then a word
  // arriving directly), emit one bit, and park any other arriving word in
  // the skid. The last chain bit also drops the rest of its word.
  always_comb begin
    buf_d       = buf_q;
    idx_d       = idx_q;
    buf_v_d     = buf_v_q;
    skid_d      = skid_q;
    skid_v_d    = skid_v_q;
    prog_en_d   = 1'b0;
    prog_in_d   = 1'b0;
    cur_word    = buf_q;
    cur_idx     = idx_q;
    cur_v       = buf_v_q;
    take_direct = 1'b0;
    if (!run) begin
      buf_v_d  = 1'b0;
      skid_v_d = 1'b0;
      idx_d    = '0;
    end else begin
      if (!buf_v_q && skid_v_q) begin
        cur_word = skid_q;
        cur_idx  = '0;
        cur_v    = 1'b1;
        skid_v_d = 1'b0;
      end else if (!buf_v_q && s_hs) begin
        cur_word    = s_data;
        cur_idx     = '0;
        cur_v       = 1'b1;
        take_direct = 1'b1;
      end
      if (cur_v && remaining != '0) begin
        prog_en_d = 1'b1;
        prog_in_d = cur_word[cur_idx];
        buf_d     = cur_word;
        if (cur_idx == IDX_W'(WORD_W - 1) || remaining == CNT_W'(1)) begin
          buf_v_d = 1'b0;
          idx_d   = '0;
        end else begin
          buf_v_d = 1'b1;
          idx_d   = cur_idx + IDX_W'(1);
        end
      end else begin
        buf_v_d = 1'b0;
        idx_d   = '0;
      end
      if (s_hs && !take_direct) begin
        skid_d   = s_data;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      buf_q     <= '0;
      idx_q     <= '0;
      buf_v_q   <= 1'b0;
      skid_q    <= '0;
      skid_v_q  <= 1'b0;
      prog_in_q <= 1'b0;
      prog_en_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      buf_v_q   <= buf_v_d;
      skid_q    <= skid_d;
      skid_v_q  <= skid_v_d;
      prog_in_q <= prog_in_d;
      prog_en_q <= prog_en_d;
    end
  end

  assign prog_in = prog_in_q;
  assign prog_en = prog_en_q;

endmodule

// File: rtl/config_loader.sv
// config_loader
// Loads a CHAIN_LEN-bit configuration scan chain from a word stream and can
// optionally verify it by re-shifting the same stream and comparing the
// chain tail against the bits being shifted in.
// Ports:
//   prog_clk, prog_rst_n : clock (also clocks the chain), async active-low reset
//   start, verify, abort : pass control; verify is sampled with start
//   s_data/s_valid/s_ready : bitstream words, bit 0 shifted first
//   prog_in, prog_en, prog_out : chain data, shift enable, chain tail
//   busy, done           : pass in progress, one-cycle completion pulse
//   err_cnt, mismatch    : saturating verify mismatch count, nonzero flag
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 4416,
  parameter int WORD_W    = 32,
  parameter int ERR_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              mismatch
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, remaining;
  logic [ERR_W-1:0] err_q, err_d;
  logic             verify_q, verify_d, busy_q, busy_d, done_q, done_d;
  logic             run;

  // The bit already on prog_en this cycle is issued but not yet counted,
  // so it is excluded from what the serializer may still emit.
  assign remaining = CNT_W'(CHAIN_LEN) - bit_cnt_q - CNT_W'(prog_en);
  assign run       = (state_q == RUN) && !abort;

  word_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_ser (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .run        (run),
    .remaining  (remaining),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .prog_in    (prog_in),
    .prog_en    (prog_en)
  );

  // Pass control: count completed shifts, compare the chain tail during
  // verify passes, and leave through FLUSH so done is a single pulse.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = err_q;
    verify_d  = verify_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = RUN;
          bit_cnt_d = '0;
          err_d     = '0;
          verify_d  = verify;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (prog_en) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (verify_q && (prog_out != prog_in) && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
          end
          if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
            state_d = FLUSH;
            done_d  = 1'b1;
          end
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      err_q     <= '0;
      verify_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
      verify_q  <= verify_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err_cnt  = err_q;
  assign mismatch = (err_q != '0);

endmodule
